// File: rtl/numint_pkg.sv
// Shared constants and saturation helpers for the numerical integrator.
package numint_pkg;

    // Width of the time-step numerator DT_NUM.
    localparam int unsigned NUMINT_DT_W  = 16;
    // Widest intermediate the helpers handle; covers N + 2 + NUMINT_DT_W for N up to 110.
    localparam int unsigned NUMINT_MAX_W = 128;

    // Largest signed value representable in n bits, sign-extended to NUMINT_MAX_W.
    function automatic logic signed [NUMINT_MAX_W-1:0] numint_max(input int unsigned n);
        logic signed [NUMINT_MAX_W-1:0] one;
        one = NUMINT_MAX_W'(1);
        return (one <<< (n - 1)) - one;
    endfunction

    // Smallest signed value representable in n bits, sign-extended to NUMINT_MAX_W.
    function automatic logic signed [NUMINT_MAX_W-1:0] numint_min(input int unsigned n);
        return ~numint_max(n);
    endfunction

    // Clamp a wide signed value into the n-bit signed range; caller keeps the low n bits.
    function automatic logic signed [NUMINT_MAX_W-1:0] sat_trunc(
        input logic signed [NUMINT_MAX_W-1:0] v,
        input int unsigned                    n
    );
        if (v > numint_max(n)) begin
            return numint_max(n);
        end else if (v < numint_min(n)) begin
            return numint_min(n);
        end
        return v;
    endfunction

endpackage

// File: rtl/numint_sat_add.sv
// N-bit signed saturating adder, purely combinational.
module numint_sat_add
    import numint_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic signed [N-1:0] i_a,
    input  logic signed [N-1:0] i_b,
    output logic signed [N-1:0] o_sum
);

    logic signed [N:0] w_full;

    // Add with one guard bit; a guard/sign disagreement means the N-bit result overflowed.
    always_comb begin
        w_full = (N+1)'(i_a) + (N+1)'(i_b);
        o_sum  = w_full[N-1:0];
        if (w_full[N] != w_full[N-1]) begin
            o_sum = w_full[N] ? N'(numint_min(N)) : N'(numint_max(N));
        end
    end

endmodule

// File: rtl/numerical_integral.sv
// Signed fixed-point running integrator with a saturating accumulator.
// Build option NUMINT_TRAPEZOID_EN selects the trapezoidal rule; otherwise forward Euler.
module numerical_integral
    import numint_pkg::*;
#(
    parameter int unsigned N        = 64,
    parameter int unsigned DT_NUM   = 1,
    parameter int unsigned DT_SHIFT = 0
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic signed [N-1:0] signal_input,
    input  logic                start_integration,
    output logic signed [N-1:0] integral_result
);

    // (N+1)-bit sum times a zero-extended 17-bit step numerator.
    localparam int unsigned               LP_PW     = N + 2 + NUMINT_DT_W;
    localparam logic [NUMINT_DT_W-1:0]    LP_DT     = NUMINT_DT_W'(DT_NUM);
    localparam logic signed [LP_PW-1:0]   LP_DT_EXT = LP_PW'({1'b0, LP_DT});

    logic signed [N-1:0]     r_acc;
    logic signed [N:0]       w_sum;
    logic signed [LP_PW-1:0] w_prod;
    logic signed [LP_PW-1:0] w_shift;
    logic signed [N-1:0]     w_inc;
    logic signed [N-1:0]     w_acc_next;

`ifdef NUMINT_TRAPEZOID_EN
    logic signed [N-1:0] r_x_prev;
    logic                r_prev_valid;

    // Trapezoid: a restarted run pairs the sample with itself, hence one extra shift bit.
    always_comb begin
        w_sum   = (N+1)'(signal_input)
                + (r_prev_valid ? (N+1)'(r_x_prev) : (N+1)'(signal_input));
        w_prod  = LP_PW'(w_sum) * LP_DT_EXT;
        w_shift = w_prod >>> (DT_SHIFT + 1);
        w_inc   = N'(sat_trunc(NUMINT_MAX_W'(w_shift), N));
    end

    // Previous-sample history; any idle cycle breaks the trapezoid chain.
    always_ff @(posedge clk) begin
        if (resetb) begin
            r_x_prev     <= '0;
            r_prev_valid <= 1'b0;
        end else if (start_integration) begin
            r_x_prev     <= signal_input;
            r_prev_valid <= 1'b1;
        end else begin
            r_prev_valid <= 1'b0;
        end
    end
`else
    // Forward Euler: scale the current sample only.
    always_comb begin
        w_sum   = (N+1)'(signal_input);
        w_prod  = LP_PW'(w_sum) * LP_DT_EXT;
        w_shift = w_prod >>> DT_SHIFT;
        w_inc   = N'(sat_trunc(NUMINT_MAX_W'(w_shift), N));
    end
`endif

    numint_sat_add #(
        .N (N)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_inc),
        .o_sum (w_acc_next)
    );

    // Accumulator: reset wins over enable, holds while enable is low.
    always_ff @(posedge clk) begin
        if (resetb) begin
            r_acc <= '0;
        end else if (start_integration) begin
            r_acc <= w_acc_next;
        end
    end

    assign integral_result = r_acc;

endmodule

// File: tb/tb_numerical_integral.sv
// Self-checking bench: default instance plus a DT_NUM=3, DT_SHIFT=2 instance,
// both compared against a wide-arithmetic reference model each cycle.
module tb_numerical_integral;

    localparam logic signed [63:0] P62  = 64'sh4000_0000_0000_0000;
    localparam logic signed [63:0] SMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [63:0] SMIN = 64'sh8000_0000_0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [63:0] x;
    logic signed [63:0] res_a;
    logic signed [63:0] res_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state per instance.
    logic signed [63:0] m_acc [2];
    logic signed [63:0] m_xp  [2];
    logic               m_pv  [2];

    always #5 clk = ~clk;

    numerical_integral #(.N(64), .DT_NUM(1), .DT_SHIFT(0)) u_dut_a (
        .clk               (clk),
        .resetb            (rst),
        .signal_input      (x),
        .start_integration (en),
        .integral_result   (res_a)
    );

    numerical_integral #(.N(64), .DT_NUM(3), .DT_SHIFT(2)) u_dut_b (
        .clk               (clk),
        .resetb            (rst),
        .signal_input      (x),
        .start_integration (en),
        .integral_result   (res_b)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [127:0] clamp64(input logic signed [127:0] v);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = 128'(SMAX);
        lo = 128'(SMIN);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Next accumulator value from the integration rule using plain wide arithmetic.
    function automatic logic signed [63:0] model_next(
        input logic signed [63:0] acc, input logic signed [63:0] xv,
        input logic signed [63:0] xp, input logic pv,
        input int dtn, input int dts
    );
        logic signed [127:0] s, p, d, q, t;
        int sh;
`ifdef NUMINT_TRAPEZOID_EN
        s  = 128'(xv) + (pv ? 128'(xp) : 128'(xv));
        sh = dts + 1;
`else
        s  = 128'(xv);
        sh = dts;
        if (pv && xp == xp) sh = dts;
`endif
        p = s * 128'(dtn);
        d = 128'(1) << sh;
        q = p / d;
        // Floor toward minus infinity.
        if ((p % d) != 0 && p < 0) q = q - 128'(1);
        q = clamp64(q);
        t = clamp64(128'(acc) + q);
        return t[63:0];
    endfunction

    // Drive one cycle, advance the model, then compare both instances.
    task automatic step(input logic r, input logic e, input logic signed [63:0] xv,
                        input string tag);
        rst = r;
        en  = e;
        x   = xv;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_acc[k] = '0;
                m_xp[k]  = '0;
                m_pv[k]  = 1'b0;
            end else if (e) begin
                m_acc[k] = model_next(m_acc[k], xv, m_xp[k], m_pv[k],
                                      (k == 0) ? 1 : 3, (k == 0) ? 0 : 2);
                m_xp[k]  = xv;
                m_pv[k]  = 1'b1;
            end else begin
                m_pv[k]  = 1'b0;
            end
        end
        #1;
        check({tag, "_a"}, res_a, m_acc[0]);
        check({tag, "_b"}, res_b, m_acc[1]);
    endtask

    initial begin
        logic signed [63:0] rx;
        rst = 1'b1;
        en  = 1'b1;
        x   = 64'sd7;

        // Reset held with enable high.
        step(1'b1, 1'b1, 64'sd7, "reset0");
        check("reset0_const", res_a, 64'sd0);
        step(1'b1, 1'b1, 64'sd7, "reset1");
        check("reset1_const", res_a, 64'sd0);

        // Constant 5 for four cycles, then hold with enable low.
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 64'sd5, "const5");
            check("const5_val", res_a, 64'(5 * i));
        end
        step(1'b0, 1'b0, 64'sd100, "hold");
        check("hold_val", res_a, 64'sd20);

        // Mid-operation reset, then first-sample restart.
        step(1'b1, 1'b1, 64'sd3, "midreset");
        check("midreset_val", res_a, 64'sd0);
        step(1'b0, 1'b1, 64'sd8, "after_reset");
        check("after_reset_val", res_a, 64'sd8);

        // Ramp from a fresh reset.
        step(1'b1, 1'b0, 64'sd0, "ramp_rst");
        step(1'b0, 1'b1, 64'sd0, "ramp0");
        step(1'b0, 1'b1, 64'sd2, "ramp1");
        step(1'b0, 1'b1, 64'sd4, "ramp2");

        // Scaling on instance b: 4,4,4 then -1.
        step(1'b1, 1'b0, 64'sd0, "scale_rst");
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, 64'sd4, "scale4");
            check("scale4_b_val", res_b, 64'(3 * i));
        end
        step(1'b0, 1'b1, -64'sd1, "scale_neg");

        // Positive saturation and recovery.
        step(1'b1, 1'b0, 64'sd0, "satp_rst");
        step(1'b0, 1'b1, P62, "satp0");
        check("satp0_val", res_a, P62);
        step(1'b0, 1'b1, P62, "satp1");
        check("satp1_val", res_a, SMAX);
        step(1'b0, 1'b1, P62, "satp2");
        check("satp2_val", res_a, SMAX);
        step(1'b0, 1'b1, -64'sd1, "satp_back");

        // Negative saturation and recovery.
        step(1'b1, 1'b0, 64'sd0, "satn_rst");
        step(1'b0, 1'b1, -P62, "satn0");
        check("satn0_val", res_a, -P62);
        step(1'b0, 1'b1, -P62, "satn1");
        check("satn1_val", res_a, SMIN);
        step(1'b0, 1'b1, -P62, "satn2");
        check("satn2_val", res_a, SMIN);
        step(1'b0, 1'b1, 64'sd1, "satn_back");

        // Enable toggling every cycle.
        step(1'b1, 1'b0, 64'sd0, "tog_rst");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, i[0], 64'(10 * i - 30), "toggle");
        end

        // Randomized phase: mixed small and full-range samples, random enable, rare reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx = {$urandom, $urandom};
            end else begin
                rx = 64'($signed(32'($urandom_range(0, 2000)))) - 64'sd1000;
            end
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), rx, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
